// File: rtl/seq_divider_pkg.sv
// Shared constants and FSM encoding for the sequential signed divider.
// Imported by seq_divider and div_step.
package seq_divider_pkg;

  localparam int DATA_WIDTH = 32;
  // Wide enough to hold DATA_WIDTH iterations plus the terminal increment.
  localparam int COUNT_W    = 6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_FIX    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {rem,q} left, trial-subtract |divisor|, restore on borrow.
// Purely combinational so a single step can be checked on its own.
module div_step #(
  parameter int W = seq_divider_pkg::DATA_WIDTH
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_q,
  input  logic [W-1:0] i_dvs,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_q
);

  logic [W:0] w_rem_sh;
  logic [W:0] w_trial;
  logic       w_ge;

  assign w_rem_sh = {i_rem, i_q[W-1]};
  assign w_trial  = w_rem_sh - {1'b0, i_dvs};

  // A shifted remainder at or above 2^W always clears the divisor, even when the
  // (W+1)-bit trial result would otherwise look negative.
  assign w_ge = w_rem_sh[W] | ~w_trial[W];

  assign o_rem = w_ge ? w_trial[W-1:0] : w_rem_sh[W-1:0];
  assign o_q   = {i_q[W-2:0], w_ge};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider for the DIV path: quotient -> LO, remainder -> HI.
// Build option DIV_ZERO_FLAG_EN adds the div_zero output and a short path for a zero divisor.
module seq_divider #(
  parameter int DATA_WIDTH = seq_divider_pkg::DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
`ifdef DIV_ZERO_FLAG_EN
  output logic                  div_zero,
`endif
  output logic [1:0]            o_dbg_state
);

  import seq_divider_pkg::*;

  localparam logic [COUNT_W-1:0] LAST_STEP = COUNT_W'(DATA_WIDTH - 1);

  state_t                  r_state;
  logic [COUNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0]   r_rem;
  logic [DATA_WIDTH-1:0]   r_q;
  logic [DATA_WIDTH-1:0]   r_dvs;
  logic                    r_sign_dvd;
  logic                    r_sign_dvs;
  logic                    r_busy;
  logic                    r_done;
  logic [DATA_WIDTH-1:0]   r_quot;
  logic [DATA_WIDTH-1:0]   r_remd;
  logic [DATA_WIDTH-1:0]   w_rem_nxt;
  logic [DATA_WIDTH-1:0]   w_q_nxt;
`ifdef DIV_ZERO_FLAG_EN
  logic                    r_dz;
  logic                    r_div_zero;
`endif

  // An unsigned W-bit result holds the magnitude of -2^(W-1) exactly.
  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? -v : v;
  endfunction

  div_step #(.W(DATA_WIDTH)) u_step (
    .i_rem (r_rem),
    .i_q   (r_q),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nxt),
    .o_q   (w_q_nxt)
  );

  // Handshake: start is accepted only in IDLE; busy rises on the accepting edge and
  // drops when DONE exits; done is a one-cycle pulse while in DONE; results hold until the next FIX.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_dvs      <= '0;
      r_sign_dvd <= 1'b0;
      r_sign_dvs <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_quot     <= '0;
      r_remd     <= '0;
`ifdef DIV_ZERO_FLAG_EN
      r_dz       <= 1'b0;
      r_div_zero <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign_dvd <= dividend[DATA_WIDTH-1];
            r_sign_dvs <= divisor[DATA_WIDTH-1];
            r_q        <= magnitude(dividend);
            r_dvs      <= magnitude(divisor);
            r_rem      <= '0;
            r_count    <= '0;
            r_busy     <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
            if (divisor == '0) begin
              // Skip the iterations; FIX restores the dividend's sign onto its magnitude.
              r_dz    <= 1'b1;
              r_rem   <= magnitude(dividend);
              r_state <= S_FIX;
            end else begin
              r_dz    <= 1'b0;
              r_state <= S_DIVIDE;
            end
`else
            r_state    <= S_DIVIDE;
`endif
          end
        end

        S_DIVIDE: begin
          r_rem   <= w_rem_nxt;
          r_q     <= w_q_nxt;
          r_count <= r_count + 1'b1;
          if (r_count == LAST_STEP) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
`ifdef DIV_ZERO_FLAG_EN
          if (r_dz) begin
            r_quot     <= '1;
            r_div_zero <= 1'b1;
          end else begin
            r_quot     <= (r_sign_dvd ^ r_sign_dvs) ? -r_q : r_q;
          end
`else
          r_quot  <= (r_sign_dvd ^ r_sign_dvs) ? -r_q : r_q;
`endif
          // Truncating division: the remainder follows the dividend's sign.
          r_remd  <= r_sign_dvd ? -r_rem : r_rem;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end

        S_DONE: begin
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
          r_div_zero <= 1'b0;
`endif
          r_state    <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remd;
  assign o_dbg_state = r_state;
`ifdef DIV_ZERO_FLAG_EN
  assign div_zero    = r_div_zero;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: signed cases, -2^31 / -1, zero divisor, abort, ignored start.
// Honours DIV_ZERO_FLAG_EN for the zero-divisor latency, values and flag.
module tb_seq_divider;

  import seq_divider_pkg::*;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [1:0]  dbg_state;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero;
  localparam int          DZ_LAT    = 1;
  localparam logic [31:0] NEG_DZ_Q  = 32'hFFFF_FFFF;
`else
  localparam int          DZ_LAT    = 33;
  localparam logic [31:0] NEG_DZ_Q  = 32'h0000_0001;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  seq_divider dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
`ifdef DIV_ZERO_FLAG_EN
    .div_zero    (div_zero),
`endif
    .o_dbg_state (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // poke_at >= 0 pulses start with different operands at that many edges into the operation.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input int elat,
                        input bit edz, input int poke_at);
    int lat;
    int busy_low;
    bit seen;
    check({tag, "_idle"}, 32'(dbg_state), 32'(S_IDLE));
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    busy_low = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      if (lat == poke_at) begin
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd1;
      end
      tick();
      start = 1'b0;
      lat++;
      if (busy !== 1'b1) busy_low++;
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_busy_hold"}, 32'(busy_low), 32'd0);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
`ifdef DIV_ZERO_FLAG_EN
    check({tag, "_dz"}, 32'(div_zero), 32'(edz));
`endif
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int extra_done;
    clear    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    clear = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    run_op("pos_pos", 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0, -1);
    run_op("neg_pos", -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33, 1'b0, -1);
    run_op("pos_neg", 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 33, 1'b0, -1);
    run_op("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 1'b0, -1);
    run_op("neg_neg", -32'sd7, -32'sd2, 32'd3, 32'hFFFF_FFFF, 33, 1'b0, -1);
    run_op("div0_pos", 32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, DZ_LAT, 1'b1, -1);
    run_op("div0_neg", -32'sd55, 32'd0, NEG_DZ_Q, 32'hFFFF_FFC9, DZ_LAT, 1'b1, -1);

    // Abort after ten iterations; outputs still hold the previous result until clear.
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("abort_mid", 32'(dbg_state), 32'(S_DIVIDE));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q", quotient, 32'd0);
    check("abort_r", remainder, 32'd0);
    check("abort_state", 32'(dbg_state), 32'(S_IDLE));
    extra_done = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) extra_done++;
    end
    check("abort_no_done", 32'(extra_done), 32'd0);

    run_op("after_abort", 32'd9, 32'd3, 32'd3, 32'd0, 33, 1'b0, -1);

    run_op("ignored_start", 32'd20, 32'd6, 32'd3, 32'd2, 33, 1'b0, 5);
    extra_done = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) extra_done++;
    end
    check("ignored_no_done", 32'(extra_done), 32'd0);
    check("ignored_q_hold", quotient, 32'd3);
    check("ignored_r_hold", remainder, 32'd2);
    check("ignored_idle", 32'(dbg_state), 32'(S_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
